// File: rtl/anim_ctrl_input.sv
// Button front end for the spinner animator: synchronises and debounces four push
// buttons, keeps speed/direction/tail settings and generates the animation step tick.
module anim_ctrl_input #(
  parameter int DEBOUNCE_WIDTH = 16,
  parameter int TICK_SHIFT     = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_faster,
  input  logic       btn_slower,
  input  logic       btn_dir,
  input  logic       btn_tail,
  output logic [2:0] speed,
  output logic       direction,
  output logic       tail,
  output logic       step_tick,
  output logic       settings_changed
);

  localparam int PW = TICK_SHIFT + 4;

  // bit order everywhere: {tail, dir, slower, faster}
  logic [3:0]                raw_s;
  logic [3:0]                sync1_r;
  logic [3:0]                sync2_r;
  logic [3:0]                stable_r;
  logic [3:0]                stable_d_r;
  logic [DEBOUNCE_WIDTH-1:0] db_cnt_r [4];
  logic [3:0]                press_s;

  logic [2:0]    speed_nxt_s;
  logic          dir_nxt_s;
  logic          tail_nxt_s;
  logic          changed_s;
  logic [3:0]    base_s;
  logic [PW-1:0] period_m1_s;
  logic [PW-1:0] tick_cnt_r;

  assign raw_s   = {btn_tail, btn_dir, btn_slower, btn_faster};
  assign press_s = stable_r & ~stable_d_r;

  // Synchronisers and per-button debounce; a level is accepted on its 2^W-th disagreeing cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r    <= 4'b0000;
      sync2_r    <= 4'b0000;
      stable_r   <= 4'b0000;
      stable_d_r <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        db_cnt_r[i] <= {DEBOUNCE_WIDTH{1'b0}};
      end
    end else begin
      sync1_r    <= raw_s;
      sync2_r    <= sync1_r;
      stable_d_r <= stable_r;
      for (int i = 0; i < 4; i++) begin
        if (sync2_r[i] == stable_r[i]) begin
          db_cnt_r[i] <= {DEBOUNCE_WIDTH{1'b0}};
        end else if (&db_cnt_r[i]) begin
          stable_r[i] <= sync2_r[i];
          db_cnt_r[i] <= {DEBOUNCE_WIDTH{1'b0}};
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DEBOUNCE_WIDTH'(1'b1);
        end
      end
    end
  end

  // Next settings from press events; opposing speed presses cancel.
  always_comb begin
    speed_nxt_s = speed;
    if (press_s[0] && !press_s[1] && (speed != 3'd7)) begin
      speed_nxt_s = speed + 3'd1;
    end else if (press_s[1] && !press_s[0] && (speed != 3'd0)) begin
      speed_nxt_s = speed - 3'd1;
    end else begin
      speed_nxt_s = speed;
    end
    dir_nxt_s  = direction ^ press_s[2];
    tail_nxt_s = tail ^ press_s[3];
    changed_s  = (speed_nxt_s != speed) | press_s[2] | press_s[3];
  end

  // Settings registers and the change pulse, which coincides with the first cycle of new values.
  always_ff @(posedge clk) begin
    if (reset) begin
      speed            <= 3'd4;
      direction        <= 1'b1;
      tail             <= 1'b0;
      settings_changed <= 1'b0;
    end else begin
      speed            <= speed_nxt_s;
      direction        <= dir_nxt_s;
      tail             <= tail_nxt_s;
      settings_changed <= changed_s;
    end
  end

  // Period follows the live speed so a change takes effect mid-period.
  assign base_s      = 4'd8 - {1'b0, speed};
  assign period_m1_s = (PW'(base_s) << TICK_SHIFT) - PW'(1'b1);

  // Step tick generator.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_r <= {PW{1'b0}};
      step_tick  <= 1'b0;
    end else if (tick_cnt_r >= period_m1_s) begin
      tick_cnt_r <= {PW{1'b0}};
      step_tick  <= 1'b1;
    end else begin
      tick_cnt_r <= tick_cnt_r + PW'(1'b1);
      step_tick  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_anim_ctrl_input.sv
// Testbench for anim_ctrl_input: directed table, hand-written corner sequences and
// randomized button traffic checked every cycle against a behavioural model.
module tb_anim_ctrl_input;

  localparam int DW = 2;
  localparam int SH = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn = 4'b0000;  // {tail, dir, slower, faster}
  logic [2:0] speed;
  logic       direction, tail, step_tick, settings_changed;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;

  // behavioural model state
  bit m_syn1 [4], m_syn2 [4], m_acc [4], m_accp [4];
  int m_run [4];
  int m_speed, m_since;
  bit m_dir, m_tail, m_tick, m_chg;

  typedef struct {
    logic [3:0] btns;
    int         hold;
    int         exp_speed;
    logic       exp_dir;
    logic       exp_tail;
    int         exp_pulses;
  } vec_t;
  vec_t vecs [11];

  anim_ctrl_input #(.DEBOUNCE_WIDTH(DW), .TICK_SHIFT(SH)) dut (
    .clk              (clk),
    .reset            (reset),
    .btn_faster       (btn[0]),
    .btn_slower       (btn[1]),
    .btn_dir          (btn[2]),
    .btn_tail         (btn[3]),
    .speed            (speed),
    .direction        (direction),
    .tail             (tail),
    .step_tick        (step_tick),
    .settings_changed (settings_changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge: advance the model with the inputs seen at that edge, then compare.
  task automatic cyc();
    bit p [4];
    int nsp, period;
    @(posedge clk);
    #1;
    if (reset) begin
      for (int b = 0; b < 4; b++) begin
        m_syn1[b] = 0; m_syn2[b] = 0; m_acc[b] = 0; m_accp[b] = 0; m_run[b] = 0;
      end
      m_speed = 4; m_dir = 1; m_tail = 0; m_tick = 0; m_chg = 0; m_since = 0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        p[b] = m_acc[b] && !m_accp[b];
        m_accp[b] = m_acc[b];
        if (m_syn2[b] != m_acc[b]) begin
          m_run[b]++;
          if (m_run[b] == (1 << DW)) begin
            m_acc[b] = m_syn2[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
        m_syn2[b] = m_syn1[b];
        m_syn1[b] = btn[b];
      end
      nsp = m_speed + int'(p[0]) - int'(p[1]);
      if (nsp > 7) nsp = 7;
      if (nsp < 0) nsp = 0;
      m_chg = (nsp != m_speed) || p[2] || p[3];
      period = (8 - m_speed) * (1 << SH);
      if (m_since >= period - 1) begin
        m_tick = 1; m_since = 0;
      end else begin
        m_tick = 0; m_since++;
      end
      m_speed = nsp;
      m_dir  = m_dir ^ p[2];
      m_tail = m_tail ^ p[3];
    end
    if (settings_changed) pulse_cnt++;
    check("cycle_model", int'({speed, direction, tail, step_tick, settings_changed}),
          int'({3'(m_speed), m_dir, m_tail, m_tick, m_chg}));
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      cyc();
      if (step_tick) begin
        n = i;
        break;
      end
    end
    if (n == 0) check("tick_timeout", 0, 1);
  endtask

  task automatic measure_period(input string name, input int exp);
    int n;
    wait_tick(n);
    wait_tick(n);
    check(name, n, exp);
  endtask

  task automatic apply(input logic [3:0] b, input int hold, input int rel);
    btn = b;
    repeat (hold) cyc();
    btn = 4'b0000;
    repeat (rel) cyc();
  endtask

  initial begin
    int first, ticks, lat, chg_edge;

    vecs[0]  = '{4'b0001, 3, 5, 1'b1, 1'b0, 0};  // glitch
    vecs[1]  = '{4'b0001, 8, 6, 1'b1, 1'b0, 1};
    vecs[2]  = '{4'b0001, 8, 7, 1'b1, 1'b0, 1};
    vecs[3]  = '{4'b0001, 8, 7, 1'b1, 1'b0, 0};  // saturated
    vecs[4]  = '{4'b0001, 8, 7, 1'b1, 1'b0, 0};
    vecs[5]  = '{4'b0111, 8, 7, 1'b0, 1'b0, 1};  // faster+slower+dir
    vecs[6]  = '{4'b0011, 8, 7, 1'b0, 1'b0, 0};  // faster+slower cancel
    vecs[7]  = '{4'b0010, 8, 6, 1'b0, 1'b0, 1};
    vecs[8]  = '{4'b1000, 8, 6, 1'b0, 1'b1, 1};
    vecs[9]  = '{4'b1100, 8, 6, 1'b1, 1'b0, 1};
    vecs[10] = '{4'b1010, 8, 5, 1'b1, 1'b1, 1};

    // reset state
    reset = 1'b1;
    repeat (3) cyc();
    check("reset_state", int'({speed, direction, tail, step_tick, settings_changed}),
          int'({3'd4, 1'b1, 1'b0, 1'b0, 1'b0}));
    reset = 1'b0;

    // idle: first tick in cycle 16, period 16
    first = 0; ticks = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (step_tick) begin
        ticks++;
        if (first == 0) first = i;
      end
    end
    check("first_tick_cycle", first, 16);
    check("idle_tick_count", ticks, 2);
    check("idle_state", int'({speed, direction, tail}), int'({3'd4, 1'b1, 1'b0}));

    // held faster press: exact latency, one pulse
    pulse_cnt = 0; lat = 0;
    btn = 4'b0001;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (speed == 3'd5 && lat == 0) lat = i;
    end
    btn = 4'b0000;
    repeat (14) cyc();
    check("press_latency", lat, 7);
    check("press_pulses", pulse_cnt, 1);
    measure_period("period_speed5", 12);

    // table-driven press sequences
    for (int v = 0; v < 11; v++) begin
      pulse_cnt = 0;
      apply(vecs[v].btns, vecs[v].hold, 14);
      check($sformatf("vec%0d_state", v), int'({speed, direction, tail}),
            int'({3'(vecs[v].exp_speed), vecs[v].exp_dir, vecs[v].exp_tail}));
      check($sformatf("vec%0d_pulses", v), pulse_cnt, vecs[v].exp_pulses);
      if (v == 4) measure_period("period_speed7", 4);
    end

    // mid-period speed change with counter already past the new limit
    apply(4'b0010, 8, 14);
    apply(4'b0010, 8, 14);
    check("speed3_state", int'(speed), 3);
    begin
      int n;
      wait_tick(n);
    end
    repeat (10) cyc();
    btn = 4'b0001;
    chg_edge = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (speed == 3'd4) begin
        chg_edge = i;
        break;
      end
    end
    check("midperiod_change_edge", chg_edge, 7);
    check("midperiod_no_early_tick", int'(step_tick), 0);
    cyc();
    check("midperiod_tick_next_edge", int'(step_tick), 1);
    btn = 4'b0000;
    repeat (12) cyc();
    measure_period("period_speed4", 16);

    // button held through reset is only accepted after a fresh debounce
    btn = 4'b0001;
    reset = 1'b1;
    repeat (4) cyc();
    reset = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (speed == 3'd5 && lat == 0) lat = i;
    end
    check("held_through_reset_latency", lat, 7);
    btn = 4'b0000;
    repeat (12) cyc();

    // randomized traffic against the model
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        repeat ($urandom_range(1, 3)) cyc();
        reset = 1'b0;
      end
      btn = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 12)) cyc();
      btn = 4'b0000;
      repeat ($urandom_range(0, 10)) cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/anim_ctrl_input.md
ANIM_CTRL_INPUT -- requirements
Module: anim_ctrl_input

Interface
REQ-001: Parameter DEBOUNCE_WIDTH, default 16, debounce counter width; a level must persist 2^DEBOUNCE_WIDTH synchronised cycles to be accepted.
REQ-002: Parameter TICK_SHIFT, default 18, left-shift applied to the step period base.
REQ-003: clk  input  1  clock; all state updates on rising edge.
REQ-004: reset  input  1  reset, synchronous, active-high.
REQ-005: btn_faster  input  1  raw asynchronous push button, active-high; increases speed.
REQ-006: btn_slower  input  1  raw asynchronous push button, active-high; decreases speed.
REQ-007: btn_dir  input  1  raw asynchronous push button, active-high; toggles direction.
REQ-008: btn_tail  input  1  raw asynchronous push button, active-high; toggles tail enable.
REQ-009: speed  output  3  current speed setting, 0 slowest, 7 fastest.
REQ-010: direction  output  1  spin direction for the downstream animator, 1 = forward.
REQ-011: tail  output  1  fade-tail enable for the downstream animator.
REQ-012: step_tick  output  1  one-cycle pulse; the animator advances one state per pulse.
REQ-013: settings_changed  output  1  one-cycle pulse when speed, direction or tail changes.

Function
REQ-014: Each button SHALL pass through a dedicated 2-flop synchroniser before any other logic.
REQ-015: Each button SHALL have a stable flag and a DEBOUNCE_WIDTH-bit counter; counter cleared whenever synchronised value equals stable flag.
REQ-016: While synchronised value differs from stable flag, counter SHALL increment; on a disagreeing cycle with counter at all-ones, stable flag takes the synchronised value and counter clears.
REQ-017: A press event SHALL be stable flag high while its one-cycle-delayed copy is low; release events SHALL have no effect.
REQ-018: Raw-input-to-output latency SHALL be exactly 2 + 2^DEBOUNCE_WIDTH + 1 clock edges for a clean, held press.
REQ-019: Faster press SHALL increment speed, saturating at 7; slower press SHALL decrement speed, saturating at 0.
REQ-020: Faster and slower press in the same cycle SHALL leave speed unchanged and not pulse settings_changed.
REQ-021: Dir press SHALL invert direction; tail press SHALL invert tail; simultaneous presses on independent buttons SHALL all take effect in the same cycle.
REQ-022: settings_changed SHALL be high in the cycle after any of speed, direction, tail changes value; saturated presses produce no pulse.
REQ-023: Step period P SHALL be (8 - speed) << TICK_SHIFT cycles, computed in TICK_SHIFT+4 bits without overflow.
REQ-024: Tick counter SHALL count from 0; when counter >= P-1 it clears and step_tick is registered high for the next cycle only; otherwise it increments.
REQ-025: A speed change mid-period SHALL apply immediately; if counter already >= new P-1, the tick fires on the next edge.
REQ-026: step_tick SHALL never be high on two consecutive cycles unless P = 1 (not reachable with TICK_SHIFT >= 1).

Reset
REQ-027: On reset: synchronisers, stable flags, delayed copies, debounce counters, tick counter = 0; speed = 4; direction = 1; tail = 0; step_tick = 0; settings_changed = 0.
REQ-028: Reset SHALL override all events in the same cycle; a button held through reset is accepted only after a full debounce after reset falls.
REQ-029: First step_tick after reset deassertion SHALL be high in cycle P (speed 4).

Verification (DEBOUNCE_WIDTH=2, TICK_SHIFT=2)
REQ-030: Reset, idle 40 cycles -> speed=4, direction=1, tail=0; step_tick pulses every 16 cycles, first in cycle 16.
REQ-031: btn_faster held 20 cycles -> speed 4->5 exactly 7 edges after first sampled high, one settings_changed pulse; tick period becomes 12.
REQ-032: btn_faster glitch high 3 cycles -> no change in speed, no settings_changed.
REQ-033: Four separate faster presses from speed 5 -> speed 6, 7, 7, 7; settings_changed pulses twice only; tick period 4.
REQ-034: btn_faster and btn_slower pressed together, btn_dir pressed same cycle -> speed unchanged, direction=0, one settings_changed pulse.
REQ-035: Speed 0 (P=32), counter at 20, then speed raised to 7 (P=4) -> step_tick on next edge, then every 4 cycles.
